// File: rtl/sub12u_pkg.sv
// rtl/sub12u_pkg.sv - shared width, FSM state type and digit-count helpers for sub12u_serial
package sub12u_pkg;

   localparam int W = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_n(input int digit);
      return W / digit;
   endfunction

   function automatic bit digit_legal(input int digit);
      return (digit == 1) || (digit == 2) || (digit == 3) ||
             (digit == 4) || (digit == 6) || (digit == 12);
   endfunction

endpackage

// File: rtl/sub12u_serial_sub_digit.sv
// rtl/sub12u_serial_sub_digit.sv - combinational WIDTH-bit borrow-ripple slice; mask bits give a^b with no borrow
module sub_digit #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] mask,
   input  logic             bin,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   logic c;

   always_comb begin
      c = bin;
      d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (mask[i]) begin
            d[i] = a[i] ^ b[i];
            c    = 1'b0;
         end else begin
            d[i] = a[i] ^ b[i] ^ c;
            c    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
         end
      end
      bout = c;
   end

endmodule

// File: rtl/sub12u_serial.sv
// rtl/sub12u_serial.sv - digit-serial 12-bit unsigned subtractor, O = {borrow, A-B}, valid/ready on both sides
// Define SUB12_APPROX_EN to replace the APPROX_BITS LSBs with a^b and suppress their borrow.
module sub12u_serial
   import sub12u_pkg::*;
#(
   parameter int DIGIT       = 3,
   parameter int APPROX_BITS = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   O,
   output logic         busy
);

   localparam int         N    = calc_n(DIGIT);
   localparam logic [3:0] LAST = 4'(N - 1);

`ifdef SUB12_APPROX_EN
   localparam bit           APPROX_ON = 1'b1;
   localparam logic [W-1:0] AMASK     = W'((1 << APPROX_BITS) - 1);
`else
   localparam bit           APPROX_ON = 1'b0;
   localparam logic [W-1:0] AMASK     = '0;
`endif

   if (!digit_legal(DIGIT)) begin : g_bad_digit
      $error("sub12u_serial: DIGIT must be 1, 2, 3, 4, 6 or 12");
   end
   if (APPROX_ON && (APPROX_BITS < 0 || APPROX_BITS > 11)) begin : g_bad_approx
      $error("sub12u_serial: APPROX_BITS must be in 0..11");
   end

   state_t         state, state_next;
   logic [W-1:0]   a_sr, b_sr, m_sr;
   logic           borrow;
   logic [3:0]     cnt;
   logic [DIGIT-1:0] d;
   logic           bout;
   logic [W-1:0]   cat;

   sub_digit #(.WIDTH(DIGIT)) u_sub_digit (
      .a    (a_sr[DIGIT-1:0]),
      .b    (b_sr[DIGIT-1:0]),
      .mask (m_sr[DIGIT-1:0]),
      .bin  (borrow),
      .d    (d),
      .bout (bout)
   );

   // Earlier digits sit below the fresh one; the final cycle's cat is the full difference.
   if (DIGIT == W) begin : g_one_digit
      assign cat = d;
   end else begin : g_multi_digit
      logic [W-DIGIT-1:0] res;
      assign cat = {d, res};
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            res <= '0;
         end else if (state == RUN) begin
            res <= cat[W-1:DIGIT];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_next = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         m_sr   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         O      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr   <= A;
                  b_sr   <= B;
                  m_sr   <= AMASK;
                  borrow <= 1'b0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> DIGIT;
               b_sr   <= b_sr >> DIGIT;
               m_sr   <= m_sr >> DIGIT;
               borrow <= bout;
               cnt    <= cnt + 4'd1;
               if (cnt == LAST) O <= {bout, cat};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub12u_serial.sv
// tb/tb_sub12u_serial.sv - directed and sweep bench for sub12u_serial
module tb_sub12u_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] A;
   logic [11:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] O;
   logic        busy;

   int checks = 0;
   int errors = 0;

`ifdef SUB12_APPROX_EN
   localparam logic [12:0] E_800_001 = 13'h0801;
   localparam logic [12:0] E_000_001 = 13'h0001;
   localparam logic [12:0] E_001_002 = 13'h0003;
`else
   localparam logic [12:0] E_800_001 = 13'h07FF;
   localparam logic [12:0] E_000_001 = 13'h1FFF;
   localparam logic [12:0] E_001_002 = 13'h1FFF;
`endif

   always #5 clk = ~clk;

   sub12u_serial #(.DIGIT(3), .APPROX_BITS(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .O         (O),
      .busy      (busy)
   );

   logic [11:0] sw_a, sw_b;
   logic        sw_iv;
   logic [4:0]  sw_ir, sw_ov, sw_busy;
   logic [12:0] sw_o [5];
   int          sw_n [5] = '{12, 6, 3, 2, 1};

   for (genvar g = 0; g < 5; g++) begin : g_sw
      localparam int DG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 6 : 12;
      sub12u_serial #(.DIGIT(DG), .APPROX_BITS(2)) u_sw (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (sw_iv),
         .in_ready  (sw_ir[g]),
         .A         (sw_a),
         .B         (sw_b),
         .out_valid (sw_ov[g]),
         .out_ready (1'b1),
         .O         (sw_o[g]),
         .busy      (sw_busy[g])
      );
   end

   function automatic logic [12:0] model(input logic [11:0] a, input logic [11:0] b);
      logic [12:0] m;
      m = '0;
`ifdef SUB12_APPROX_EN
      m = 13'h0003;
`endif
      return (({1'b0, a} & ~m) - ({1'b0, b} & ~m)) | ({1'b0, a ^ b} & m);
   endfunction

   task automatic run_op(input logic [11:0] av, input logic [11:0] bv,
                         output int lat, output logic [12:0] res);
      A        = av;
      B        = bv;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      res = O;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      sw_iv     = 1'b0;
      sw_a      = '0;
      sw_b      = '0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (O !== 13'h0000) begin errors++; $display("FAIL reset_O: got %h expected 0000", O); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: in_ready %b busy %b expected 1 0", in_ready, busy); end
   endtask

   task automatic test_basic();
      int          lat;
      logic [12:0] res;
      out_ready = 1'b1;
      run_op(12'h800, 12'h001, lat, res);
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
      checks++; if (res !== E_800_001) begin errors++; $display("FAIL basic_800_001: got %h expected %h", res, E_800_001); end
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake: out_valid %b in_ready %b expected 0 1", out_valid, in_ready); end
      checks++; if (O !== E_800_001) begin errors++; $display("FAIL basic_O_hold: got %h expected %h", O, E_800_001); end
      run_op(12'h000, 12'h001, lat, res);
      checks++; if (res !== E_000_001) begin errors++; $display("FAIL basic_000_001: got %h expected %h", res, E_000_001); end
      @(posedge clk); @(negedge clk);
      run_op(12'hABC, 12'hABC, lat, res);
      checks++; if (res !== 13'h0000) begin errors++; $display("FAIL basic_abc_abc: got %h expected 0000", res); end
      @(posedge clk); @(negedge clk);
      run_op(12'h001, 12'h002, lat, res);
      checks++; if (res !== E_001_002 || lat !== 4) begin errors++; $display("FAIL basic_001_002: got %h lat %0d expected %h lat 4", res, lat, E_001_002); end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [12:0] res;
      out_ready = 1'b0;
      run_op(12'h123, 12'h045, lat, res);
      checks++; if (res !== 13'h00DE || lat !== 4) begin errors++; $display("FAIL bp_result: got %h lat %0d expected 00de lat 4", res, lat); end
      for (int i = 0; i < 5; i++) begin
         A        = 12'($urandom);
         B        = 12'($urandom);
         in_valid = ~in_valid;
         @(posedge clk); @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || O !== 13'h00DE) begin
            errors++;
            $display("FAIL bp_hold%0d: out_valid %b in_ready %b busy %b O %h expected 1 0 1 00de", i, out_valid, in_ready, busy, O);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || O !== 13'h00DE) begin errors++; $display("FAIL bp_release: out_valid %b in_ready %b O %h expected 0 1 00de", out_valid, in_ready, O); end
      @(posedge clk); @(negedge clk);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_single: busy %b out_valid %b expected 0 0", busy, out_valid); end
   endtask

   task automatic test_reset_mid_run();
      int          lat;
      logic [12:0] res;
      logic        seen;
      out_ready = 1'b1;
      A         = 12'h555;
      B         = 12'h111;
      in_valid  = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      checks++; if (in_ready !== 1'b1 || O !== 13'h0000 || busy !== 1'b0) begin errors++; $display("FAIL midrun_state: in_ready %b O %h busy %b expected 1 0000 0", in_ready, O, busy); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrun_no_valid: got %b expected 0", seen); end
      run_op(12'h010, 12'h008, lat, res);
      checks++; if (res !== 13'h0008 || lat !== 4) begin errors++; $display("FAIL midrun_next: got %h lat %0d expected 0008 lat 4", res, lat); end
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int acc[$];
      out_ready = 1'b1;
      A         = 12'h00F;
      B         = 12'h001;
      in_valid  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (in_ready) acc.push_back(c);
         if (out_valid) begin
            checks++;
            if (O !== 13'h000E) begin errors++; $display("FAIL b2b_result: got %h expected 000e", O); end
         end
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (acc.size() < 3) begin
         errors++;
         $display("FAIL b2b_accepts: got %0d expected at least 3", acc.size());
      end else if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
         errors++;
         $display("FAIL b2b_interval: got %0d %0d expected 6 6", acc[1] - acc[0], acc[2] - acc[1]);
      end
      repeat (8) begin @(posedge clk); @(negedge clk); end
   endtask

   task automatic test_sweep();
      logic [4:0]  done;
      logic [12:0] exp;
      int          lat;
      for (int k = 0; k < 1000; k++) begin
         case (k)
            0:       begin sw_a = 12'h000; sw_b = 12'hFFF; end
            1:       begin sw_a = 12'hFFF; sw_b = 12'h000; end
            2:       begin sw_a = 12'hFFF; sw_b = 12'hFFF; end
            default: begin sw_a = 12'($urandom); sw_b = 12'($urandom); end
         endcase
         exp = model(sw_a, sw_b);
         checks++;
         if (sw_ir !== 5'h1F || sw_busy !== 5'h00) begin
            errors++;
            $display("FAIL sweep_idle%0d: in_ready %b busy %b expected 11111 00000", k, sw_ir, sw_busy);
         end
         sw_iv = 1'b1;
         @(posedge clk); @(negedge clk);
         sw_iv = 1'b0;
         done  = '0;
         lat   = 0;
         while (done != 5'h1F && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            for (int g = 0; g < 5; g++) begin
               if (sw_ov[g] && !done[g]) begin
                  done[g] = 1'b1;
                  checks++;
                  if (lat != sw_n[g] || sw_o[g] !== exp) begin
                     errors++;
                     $display("FAIL sweep_n%0d: A %h B %h got %h lat %0d expected %h lat %0d", sw_n[g], sw_a, sw_b, sw_o[g], lat, exp, sw_n[g]);
                  end
               end
            end
         end
         if (done != 5'h1F) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: done %b expected 11111", done);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
